// File: rtl/emif_pll_phase_shift_ctrl.sv
// Initiator for the IOPLL dynamic phase-shift port: splits a step request into
// PLL-legal chunks and sequences the phase_en / phase_done handshake per chunk.
module emif_pll_phase_shift_ctrl #(
   parameter int unsigned CNTSEL_WIDTH      = 4,
   parameter int unsigned NUM_SHIFT_WIDTH   = 3,
   parameter int unsigned STEP_WIDTH        = 8,
   parameter int unsigned PHASE_EN_CYCLES   = 2,
   parameter int unsigned DONE_LOW_TIMEOUT  = 8,
   parameter int unsigned DONE_HIGH_TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       pll_locked,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [CNTSEL_WIDTH-1:0]    req_cnt_sel,
   input  logic                       req_up_dn,
   input  logic [STEP_WIDTH-1:0]      req_steps,
   output logic                       rsp_valid,
   output logic                       rsp_error,
   output logic [STEP_WIDTH-1:0]      rsp_steps_done,
   output logic                       busy,
   output logic                       pll_phase_en,
   output logic                       pll_up_dn,
   output logic [CNTSEL_WIDTH-1:0]    pll_cnt_sel,
   output logic [NUM_SHIFT_WIDTH-1:0] pll_num_phase_shifts,
   input  logic                       pll_phase_done
);

   localparam int unsigned MAX_CHUNK = (1 << NUM_SHIFT_WIDTH) - 1;
   localparam int unsigned TMO_MAX   = (DONE_LOW_TIMEOUT > DONE_HIGH_TIMEOUT) ?
                                       DONE_LOW_TIMEOUT : DONE_HIGH_TIMEOUT;
   localparam int unsigned TIMER_W   = $clog2(TMO_MAX) + 1;
   localparam int unsigned EN_W      = $clog2(PHASE_EN_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ASSERT, S_WAIT_LOW, S_WAIT_HIGH, S_GAP, S_RESP
   } state_t;

   state_t                     state_q, state_d;
   logic [STEP_WIDTH-1:0]      remaining_q, remaining_d;
   logic [STEP_WIDTH-1:0]      steps_done_q, steps_done_d;
   logic [TIMER_W-1:0]         timer_q, timer_d;
   logic [EN_W-1:0]            en_cnt_q, en_cnt_d;
   logic                       done_meta_q, done_s_q;
   logic                       req_ready_q, req_ready_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic                       rsp_error_q, rsp_error_d;
   logic [STEP_WIDTH-1:0]      rsp_steps_done_q, rsp_steps_done_d;
   logic                       busy_q, busy_d;
   logic                       pll_phase_en_q, pll_phase_en_d;
   logic                       pll_up_dn_q, pll_up_dn_d;
   logic [CNTSEL_WIDTH-1:0]    pll_cnt_sel_q, pll_cnt_sel_d;
   logic [NUM_SHIFT_WIDTH-1:0] pll_num_phase_shifts_q, pll_num_phase_shifts_d;
   logic                       chunk_done;
   logic [STEP_WIDTH-1:0]      steps_sum, rem_left;

   function automatic logic [NUM_SHIFT_WIDTH-1:0] next_chunk(input logic [STEP_WIDTH-1:0] r);
      if (r > STEP_WIDTH'(MAX_CHUNK)) return NUM_SHIFT_WIDTH'(MAX_CHUNK);
      return r[NUM_SHIFT_WIDTH-1:0];
   endfunction

   always_comb begin
      state_d                = state_q;
      remaining_d            = remaining_q;
      steps_done_d           = steps_done_q;
      timer_d                = timer_q;
      en_cnt_d               = en_cnt_q;
      req_ready_d            = req_ready_q;
      rsp_valid_d            = 1'b0;
      rsp_error_d            = rsp_error_q;
      rsp_steps_done_d       = rsp_steps_done_q;
      busy_d                 = busy_q;
      pll_phase_en_d         = pll_phase_en_q;
      pll_up_dn_d            = pll_up_dn_q;
      pll_cnt_sel_d          = pll_cnt_sel_q;
      pll_num_phase_shifts_d = pll_num_phase_shifts_q;
      chunk_done             = 1'b0;
      // The chunk in flight is the registered shift count presented to the PLL.
      steps_sum              = steps_done_q + STEP_WIDTH'(pll_num_phase_shifts_q);
      rem_left               = remaining_q - STEP_WIDTH'(pll_num_phase_shifts_q);

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               req_ready_d  = 1'b0;
               busy_d       = 1'b1;
               steps_done_d = '0;
               if (req_steps == '0 || !pll_locked) begin
                  state_d          = S_RESP;
                  rsp_valid_d      = 1'b1;
                  rsp_error_d      = (req_steps != '0);
                  rsp_steps_done_d = '0;
               end else begin
                  state_d                = S_ASSERT;
                  remaining_d            = req_steps;
                  en_cnt_d               = '0;
                  pll_cnt_sel_d          = req_cnt_sel;
                  pll_up_dn_d            = req_up_dn;
                  pll_num_phase_shifts_d = next_chunk(req_steps);
               end
            end
         end
         S_ASSERT: begin
            if (en_cnt_q == EN_W'(PHASE_EN_CYCLES)) begin
               pll_phase_en_d = 1'b0;
               state_d        = S_WAIT_LOW;
               timer_d        = '0;
            end else begin
               pll_phase_en_d = 1'b1;
               en_cnt_d       = en_cnt_q + 1'b1;
            end
         end
         S_WAIT_LOW: begin
            if (!done_s_q) begin
               state_d = S_WAIT_HIGH;
               timer_d = '0;
            end else if (timer_q == TIMER_W'(DONE_LOW_TIMEOUT - 1)) begin
               chunk_done = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (done_s_q) begin
               chunk_done = 1'b1;
            end else if (timer_q == TIMER_W'(DONE_HIGH_TIMEOUT - 1)) begin
               state_d          = S_RESP;
               rsp_valid_d      = 1'b1;
               rsp_error_d      = 1'b1;
               rsp_steps_done_d = steps_done_q;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_GAP: begin
            state_d                = S_ASSERT;
            en_cnt_d               = '0;
            pll_num_phase_shifts_d = next_chunk(remaining_q);
         end
         S_RESP: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      if (chunk_done) begin
         steps_done_d = steps_sum;
         remaining_d  = rem_left;
         if (rem_left == '0) begin
            state_d          = S_RESP;
            rsp_valid_d      = 1'b1;
            rsp_error_d      = 1'b0;
            rsp_steps_done_d = steps_sum;
         end else begin
            state_d = S_GAP;
         end
      end

      // Lock loss wins over any same-cycle completion or timeout; only
      // previously finished chunks are reported.
      if (!pll_locked && (state_q inside {S_ASSERT, S_WAIT_LOW, S_WAIT_HIGH, S_GAP})) begin
         pll_phase_en_d   = 1'b0;
         state_d          = S_RESP;
         rsp_valid_d      = 1'b1;
         rsp_error_d      = 1'b1;
         rsp_steps_done_d = steps_done_q;
         steps_done_d     = steps_done_q;
         remaining_d      = remaining_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q                <= S_IDLE;
         remaining_q            <= '0;
         steps_done_q           <= '0;
         timer_q                <= '0;
         en_cnt_q               <= '0;
         done_meta_q            <= 1'b1;
         done_s_q               <= 1'b1;
         req_ready_q            <= 1'b1;
         rsp_valid_q            <= 1'b0;
         rsp_error_q            <= 1'b0;
         rsp_steps_done_q       <= '0;
         busy_q                 <= 1'b0;
         pll_phase_en_q         <= 1'b0;
         pll_up_dn_q            <= 1'b0;
         pll_cnt_sel_q          <= '0;
         pll_num_phase_shifts_q <= '0;
      end else begin
         state_q                <= state_d;
         remaining_q            <= remaining_d;
         steps_done_q           <= steps_done_d;
         timer_q                <= timer_d;
         en_cnt_q               <= en_cnt_d;
         done_meta_q            <= pll_phase_done;
         done_s_q               <= done_meta_q;
         req_ready_q            <= req_ready_d;
         rsp_valid_q            <= rsp_valid_d;
         rsp_error_q            <= rsp_error_d;
         rsp_steps_done_q       <= rsp_steps_done_d;
         busy_q                 <= busy_d;
         pll_phase_en_q         <= pll_phase_en_d;
         pll_up_dn_q            <= pll_up_dn_d;
         pll_cnt_sel_q          <= pll_cnt_sel_d;
         pll_num_phase_shifts_q <= pll_num_phase_shifts_d;
      end
   end

   assign req_ready            = req_ready_q;
   assign rsp_valid            = rsp_valid_q;
   assign rsp_error            = rsp_error_q;
   assign rsp_steps_done       = rsp_steps_done_q;
   assign busy                 = busy_q;
   assign pll_phase_en         = pll_phase_en_q;
   assign pll_up_dn            = pll_up_dn_q;
   assign pll_cnt_sel          = pll_cnt_sel_q;
   assign pll_num_phase_shifts = pll_num_phase_shifts_q;

endmodule

// File: tb/tb_emif_pll_phase_shift_ctrl.sv
// Bench for emif_pll_phase_shift_ctrl: directed and random requests against a
// chunk-list model of the expected PLL handshake and response.
module tb_emif_pll_phase_shift_ctrl;

   localparam int unsigned CW       = 4;
   localparam int unsigned NW       = 3;
   localparam int unsigned SW       = 8;
   localparam int          EN_CYC   = 2;
   localparam int          LOW_TMO  = 8;
   localparam int          HIGH_TMO = 64;
   localparam int          MAXC     = 7;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pll_locked = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [CW-1:0] req_cnt_sel = '0;
   logic          req_up_dn = 1'b0;
   logic [SW-1:0] req_steps = '0;
   logic          rsp_valid, rsp_error, busy;
   logic [SW-1:0] rsp_steps_done;
   logic          pll_phase_en, pll_up_dn;
   logic [CW-1:0] pll_cnt_sel;
   logic [NW-1:0] pll_num_phase_shifts;
   logic          pll_phase_done = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   emif_pll_phase_shift_ctrl #(
      .CNTSEL_WIDTH(CW), .NUM_SHIFT_WIDTH(NW), .STEP_WIDTH(SW),
      .PHASE_EN_CYCLES(EN_CYC), .DONE_LOW_TIMEOUT(LOW_TMO), .DONE_HIGH_TIMEOUT(HIGH_TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
      .req_valid(req_valid), .req_ready(req_ready), .req_cnt_sel(req_cnt_sel),
      .req_up_dn(req_up_dn), .req_steps(req_steps),
      .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_steps_done(rsp_steps_done),
      .busy(busy), .pll_phase_en(pll_phase_en), .pll_up_dn(pll_up_dn),
      .pll_cnt_sel(pll_cnt_sel), .pll_num_phase_shifts(pll_num_phase_shifts),
      .pll_phase_done(pll_phase_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_req_ready"}, 32'(req_ready), 1);
      chk({pfx, "_busy"}, 32'(busy), 0);
      chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
      chk({pfx, "_rsp_error"}, 32'(rsp_error), 0);
      chk({pfx, "_rsp_steps"}, 32'(rsp_steps_done), 0);
      chk({pfx, "_phase_en"}, 32'(pll_phase_en), 0);
      chk({pfx, "_up_dn"}, 32'(pll_up_dn), 0);
      chk({pfx, "_cnt_sel"}, 32'(pll_cnt_sel), 0);
      chk({pfx, "_nshift"}, 32'(pll_num_phase_shifts), 0);
   endtask

   // mode 0: done tied high, 1: real done handshake, 2: done stuck low on a chunk,
   // 3: lock lost while a chunk is enabled, 4: unlocked at accept
   task automatic run_req(input int steps, input logic [CW-1:0] cs, input logic ud,
                          input int mode, input int fault_sel);
      int   chunks[$];
      int   rem, fault, exp_pulses, exp_done, cyc, pulse_idx, pulse_len, pulse_end;
      int   done_low_at, done_high_at, lock_at;
      logic exp_err, prev_en, got;

      rem = steps;
      while (rem > 0) begin
         chunks.push_back((rem > MAXC) ? MAXC : rem);
         rem -= chunks[$];
      end
      fault      = (chunks.size() > 0) ? (fault_sel % chunks.size()) : 0;
      exp_err    = 1'b0;
      exp_done   = steps;
      exp_pulses = chunks.size();
      if (mode == 4) begin
         exp_err    = (steps != 0);
         exp_done   = 0;
         exp_pulses = 0;
      end else if ((mode == 2 || mode == 3) && chunks.size() > 0) begin
         exp_err  = 1'b1;
         exp_done = 0;
         for (int i = 0; i < fault; i++) exp_done += chunks[i];
         exp_pulses = fault + 1;
      end

      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 1);
      if (mode == 4) pll_locked = 1'b0;
      req_valid   = 1'b1;
      req_steps   = SW'(steps);
      req_cnt_sel = cs;
      req_up_dn   = ud;
      @(negedge clk);
      req_valid   = 1'b0;
      req_steps   = SW'($urandom);
      req_cnt_sel = CW'($urandom);
      req_up_dn   = ~ud;
      chk("busy_after_accept", 32'(busy), 1);
      chk("req_ready_busy", 32'(req_ready), 0);

      cyc = 0; pulse_idx = 0; pulse_len = 0; pulse_end = 0;
      done_low_at = -1; done_high_at = -1; lock_at = -1;
      prev_en = 1'b0; got = 1'b0;
      while (!got && cyc < 3000) begin
         if (pll_phase_en && !prev_en) begin
            pulse_len = 0;
            if ((mode == 1) || (mode == 2 && pulse_idx == fault)) begin
               done_low_at  = cyc + int'($urandom_range(2, 4));
               done_high_at = (mode == 1) ? done_low_at + int'($urandom_range(3, 12)) : -1;
            end
            if (mode == 3 && pulse_idx == fault) begin
               pll_locked = 1'b0;
               lock_at    = cyc + 1;
            end
         end
         if (pll_phase_en) begin
            pulse_len++;
            if (pulse_idx < chunks.size())
               chk("nshift", 32'(pll_num_phase_shifts), 32'(chunks[pulse_idx]));
            chk("cnt_sel", 32'(pll_cnt_sel), 32'(cs));
            chk("up_dn", 32'(pll_up_dn), 32'(ud));
         end
         if (!pll_phase_en && prev_en) begin
            if (!(mode == 3 && pulse_idx == fault)) chk("pulse_len", 32'(pulse_len), EN_CYC);
            pulse_idx++;
            pulse_end = cyc;
         end
         if (cyc == lock_at) chk("lock_en_drop", 32'(pll_phase_en), 0);
         if (cyc == done_low_at) pll_phase_done = 1'b0;
         if (cyc == done_high_at) pll_phase_done = 1'b1;
         if (rsp_valid) begin
            got = 1'b1;
            chk("rsp_error", 32'(rsp_error), 32'(exp_err));
            chk("rsp_steps", 32'(rsp_steps_done), 32'(exp_done));
            chk("pulse_count", 32'(pulse_idx), 32'(exp_pulses));
            if (chunks.size() == 0 || mode == 4) chk("rsp_lat_nop", 32'(cyc), 0);
            if (mode == 0 && chunks.size() == 1)
               chk("rsp_lat_fast", 32'((cyc - pulse_end >= LOW_TMO) && (cyc - pulse_end <= LOW_TMO + 2)), 1);
            if (mode == 2 && chunks.size() > 0)
               chk("rsp_lat_tmo", 32'((cyc - done_low_at >= HIGH_TMO) && (cyc - done_low_at <= HIGH_TMO + 8)), 1);
         end
         prev_en = pll_phase_en;
         if (!got) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!got) chk("rsp_timeout", 0, 1);

      @(negedge clk);
      chk("rsp_one_cycle", 32'(rsp_valid), 0);
      chk("req_ready_back", 32'(req_ready), 1);
      chk("busy_clear", 32'(busy), 0);
      chk("rsp_error_hold", 32'(rsp_error), 32'(exp_err));
      chk("rsp_steps_hold", 32'(rsp_steps_done), 32'(exp_done));
      pll_locked     = 1'b1;
      pll_phase_done = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Abort a request while it waits for done to return high.
   task automatic reset_mid_wait_high();
      int   n;
      logic seen;
      @(negedge clk);
      req_valid = 1'b1; req_steps = SW'(3); req_cnt_sel = CW'(9); req_up_dn = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!pll_phase_en && n < 20) begin @(negedge clk); n++; end
      chk("rst_mid_pulse_seen", 32'(pll_phase_en), 1);
      pll_phase_done = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_mid_busy", 32'(busy), 1);
      #2 reset_n = 1'b0;
      #1 check_reset_vals("rst_mid");
      pll_phase_done = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("rst_mid_no_rsp", 32'(seen), 0);
      chk("rst_mid_ready", 32'(req_ready), 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      run_req(5, CW'(2), 1'b1, 0, 0);
      run_req(20, CW'(5), 1'b0, 0, 0);
      run_req(4, CW'(3), 1'b1, 1, 0);
      run_req(3, CW'(1), 1'b0, 2, 0);
      run_req(20, CW'(6), 1'b1, 3, 1);
      run_req(0, CW'(7), 1'b1, 0, 0);
      run_req(6, CW'(4), 1'b0, 4, 0);
      reset_mid_wait_high();

      for (int i = 0; i < 40; i++)
         run_req(int'($urandom_range(1, 40)), CW'($urandom), 1'($urandom),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
